vid_mode_seq: RTL and testbench
===============================

# vid_mode_seq

Sequencing controller for the pixel-clock video pipeline. Brings the timing generator out of reset only after the pixel PLL has been stably locked. Gates the output pins (DE/HS/VS/RGB) until the timing has run clean frames. Accepts video-mode change requests over a valid/ready handshake and applies them only at a frame boundary, so the panel never sees a torn or partial frame. Sits between the PLL, the video timing generator and the output register stage in the top level.

## Interface
- `NUM_MODES`, 4 — number of selectable timing modes; legal codes are 0..NUM_MODES-1.
- `DEFAULT_MODE`, 0 — mode applied out of reset.
- `LOCK_STABLE`, 255 — consecutive `pll_lock`-high cycles required before timing starts (1..65535).
- `BLANK_FRAMES`, 2 — vsync rising edges with output gated after every (re)start (1..15).

- `clk`  in  1  pixel clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_lock`  in  1  PLL lock indicator; treated as synchronous to `clk`.
- `vsync`  in  1  vsync from the timing generator; active high.
- `mode_req`  in  2  requested mode code.
- `mode_req_valid`  in  1  request valid.
- `mode_req_ready`  out  1  request accepted on the cycle where valid && ready.
- `mode_sel`  out  2  mode currently driven to the timing generator.
- `timing_rst`  out  1  holds the timing generator in reset when high.
- `out_en`  out  1  output-stage enable; gates DE/HS/VS/RGB to zero when low.
- `mode_err`  out  1  one-cycle pulse when an out-of-range mode is accepted.
- `frame_count`  out  8  vsync rising edges since `timing_rst` last fell; wraps.

## Operation
- Reset values: `mode_sel`=DEFAULT_MODE, `timing_rst`=1, `out_en`=0, `mode_req_ready`=0, `mode_err`=0, `frame_count`=0, state=WAIT_LOCK, lock counter=0.
- `vsync_rise` = `vsync` && !`vsync_q`, where `vsync_q` is registered. `vsync_q` resets to 1, so no false edge occurs after reset.
- States:
  - **WAIT_LOCK**: `timing_rst`=1, `out_en`=0. The lock counter increments while `pll_lock`=1 and clears to 0 when `pll_lock`=0. When the count reaches LOCK_STABLE, go to BLANK.
  - **BLANK**: `timing_rst`=0, `out_en`=0. Count `vsync_rise` events. On the BLANK_FRAMES-th edge, go to RUN.
  - **RUN**: `out_en`=1 and `mode_req_ready`=1. On a handshake:
    - out-of-range code: consume it, pulse `mode_err`, stay in RUN.
    - code equal to `mode_sel`: consume it, stay in RUN (no-op).
    - otherwise: latch the code into `pending` and go to DRAIN.
  - **DRAIN**: `out_en`=1, `mode_req_ready`=0. On `vsync_rise`, go to SWITCH.
  - **SWITCH**: lasts one cycle. `timing_rst`=1, `out_en`=0, `mode_sel`<=`pending`, `frame_count`<=0. Then go to BLANK.
- `pll_lock`=0 in any state other than WAIT_LOCK: go to WAIT_LOCK next cycle. Any in-flight pending mode is discarded; `mode_sel` keeps its last value.
- `frame_count` increments on `vsync_rise` while `timing_rst`=0. It wraps 255→0 and clears whenever `timing_rst` is 1.

## Timing
- All outputs are registered. A state entered on edge N drives its outputs from edge N.
- Handshake to DRAIN is one cycle. `out_en` falls one cycle after the `vsync_rise` cycle that ends DRAIN.
- Total output gap for a mode change is BLANK_FRAMES frames plus 1 cycle.
- `mode_req_ready` is 0 in every state except RUN. It drops the cycle after the handshake that enters DRAIN.
- Lock loss wins over a simultaneous handshake or `vsync_rise`: the request is not consumed and the next state is WAIT_LOCK.
- Asynchronous reset mid-operation forces the reset values immediately.

## Structure
- Package `vid_mode_pkg` holds:
  - the state enum (WAIT_LOCK, BLANK, RUN, DRAIN, SWITCH);
  - `MODE_W`=2;
  - mode code constants: 0=640x480, 1=800x600, 2=1280x720, 3=reserved.
- Sub-module `lock_filter` contains the lock counter. It outputs `lock_ok` and has a synchronous clear.
- The FSM, the `vsync` edge detector and the frame counter stay in `vid_mode_seq`.

## Test plan
- **Lock qualification**: reset, then `pll_lock`=1 at cycle 10 → `timing_rst` falls at cycle 10+255. A 1-cycle `pll_lock` dropout at cycle 100 restarts the count.
- **Blanking**: after lock, drive two `vsync` pulses → `out_en` rises one cycle after the second rising edge, and `frame_count`=2.
- **Mode change**: in RUN, handshake `mode_req`=2 mid-frame → `out_en` stays 1 until the next `vsync_rise`. Then `timing_rst`=1 for exactly one cycle, `mode_sel`=2, `frame_count`=0, and `out_en` returns after 2 more frames.
- **Degenerate requests**: `mode_req`=current mode → accepted, no state change. With NUM_MODES=3, `mode_req`=3 → accepted, `mode_err` high for exactly one cycle, `mode_sel` unchanged.
- **Lock loss**: drop `pll_lock` during DRAIN with `pending`=1 → next cycle WAIT_LOCK, `timing_rst`=1, `out_en`=0, `mode_sel` unchanged.
- **Wrap and reset**: 256 frames in RUN → `frame_count` wraps to 0. Assert `rst_n`=0 asynchronously mid-frame → all outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/vid_mode_pkg.sv
// Shared types and constants for the video mode sequencer.
package vid_mode_pkg;

  localparam int unsigned MODE_W = 2;

  // Mode codes understood by the timing generator
  localparam logic [MODE_W-1:0] MODE_640X480  = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_800X600  = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_1280X720 = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_RESERVED = MODE_W'(3);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    BLANK     = 3'd1,
    RUN       = 3'd2,
    DRAIN     = 3'd3,
    SWITCH    = 3'd4
  } state_e;

endpackage

// File: rtl/vid_mode_seq_if.sv
// Mode-request valid/ready handshake between requester and sequencer.
interface vid_mode_seq_if;
  import vid_mode_pkg::*;

  logic [MODE_W-1:0] mode_req;
  logic              mode_req_valid;
  logic              mode_req_ready;

  modport master (output mode_req, output mode_req_valid, input mode_req_ready);
  modport slave  (input mode_req, input mode_req_valid, output mode_req_ready);
endinterface

// File: rtl/lock_filter.sv
// Qualifies pll_lock: lock_ok rises after LOCK_STABLE consecutive high cycles.
module lock_filter #(
  parameter int unsigned LOCK_STABLE = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic clr,
  output logic lock_ok
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_ok_q, lock_ok_d;

  // Saturating run-length counter of pll_lock; any low cycle or clear restarts it
  always_comb begin
    count_d   = '0;
    lock_ok_d = 1'b0;
    if (!clr && pll_lock) begin
      count_d   = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
      lock_ok_d = (count_q >= CNT_LAST);
    end
  end

  // Counter and qualified-lock registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      lock_ok_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      lock_ok_q <= lock_ok_d;
    end
  end

  assign lock_ok = lock_ok_q;

endmodule

// File: rtl/vid_mode_seq.sv
// Video pipeline sequencer: PLL lock qualification, output blanking and
// frame-aligned mode switching.
module vid_mode_seq
  import vid_mode_pkg::*;
#(
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned LOCK_STABLE  = 255,
  parameter int unsigned BLANK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              vsync,
  vid_mode_seq_if.slave     req_if,
  output logic [MODE_W-1:0] mode_sel,
  output logic              timing_rst,
  output logic              out_en,
  output logic              mode_err,
  output logic [7:0]        frame_count
);

  localparam int unsigned FC_W    = 8;
  localparam int unsigned BLANK_W = 4;
  localparam logic [MODE_W:0]      NUM_MODES_L = (MODE_W+1)'(NUM_MODES);
  localparam logic [MODE_W-1:0]    DEFAULT_L   = MODE_W'(DEFAULT_MODE);
  localparam logic [BLANK_W-1:0]   BLANK_LAST  = BLANK_W'(BLANK_FRAMES - 1);

  state_e             state_q, state_d;
  logic [MODE_W-1:0]  pending_q, pending_d;
  logic [MODE_W-1:0]  mode_sel_q, mode_sel_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [FC_W-1:0]    frame_count_q, frame_count_d;
  logic               timing_rst_q, timing_rst_d;
  logic               out_en_q, out_en_d;
  logic               ready_q, ready_d;
  logic               mode_err_q, mode_err_d;
  logic               vsync_q;
  logic               vsync_rise;
  logic               handshake;
  logic               req_oor;
  logic               lock_ok;

  lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .clr      (state_q != WAIT_LOCK),
    .lock_ok  (lock_ok)
  );

  // Next-state, registered-output and frame counter logic
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    mode_sel_d    = mode_sel_q;
    blank_cnt_d   = blank_cnt_q;
    frame_count_d = frame_count_q;
    mode_err_d    = 1'b0;

    vsync_rise = vsync && !vsync_q;
    handshake  = req_if.mode_req_valid && ready_q;
    req_oor    = ({1'b0, req_if.mode_req} >= NUM_MODES_L);

    // Lock loss overrides any handshake or vsync edge in flight
    if (state_q != WAIT_LOCK && !pll_lock) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: if (lock_ok && pll_lock) state_d = BLANK;
        BLANK: begin
          if (vsync_rise) begin
            if (blank_cnt_q == BLANK_LAST) state_d = RUN;
            else blank_cnt_d = blank_cnt_q + BLANK_W'(1);
          end
        end
        RUN: begin
          if (handshake) begin
            if (req_oor) begin
              mode_err_d = 1'b1;
            end else if (req_if.mode_req != mode_sel_q) begin
              pending_d = req_if.mode_req;
              state_d   = DRAIN;
            end
          end
        end
        DRAIN:   if (vsync_rise) state_d = SWITCH;
        SWITCH:  state_d = BLANK;
        default: state_d = WAIT_LOCK;
      endcase
    end

    if (state_d != BLANK) blank_cnt_d = '0;
    if (state_d == SWITCH) mode_sel_d = pending_q;

    timing_rst_d = (state_d == WAIT_LOCK) || (state_d == SWITCH);
    out_en_d     = (state_d == RUN) || (state_d == DRAIN);
    ready_d      = (state_d == RUN);

    if (timing_rst_d) frame_count_d = '0;
    else if (vsync_rise && !timing_rst_q) frame_count_d = frame_count_q + FC_W'(1);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_LOCK;
      pending_q     <= DEFAULT_L;
      mode_sel_q    <= DEFAULT_L;
      blank_cnt_q   <= '0;
      frame_count_q <= '0;
      timing_rst_q  <= 1'b1;
      out_en_q      <= 1'b0;
      ready_q       <= 1'b0;
      mode_err_q    <= 1'b0;
      vsync_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mode_sel_q    <= mode_sel_d;
      blank_cnt_q   <= blank_cnt_d;
      frame_count_q <= frame_count_d;
      timing_rst_q  <= timing_rst_d;
      out_en_q      <= out_en_d;
      ready_q       <= ready_d;
      mode_err_q    <= mode_err_d;
      vsync_q       <= vsync;
    end
  end

  assign req_if.mode_req_ready = ready_q;
  assign mode_sel    = mode_sel_q;
  assign timing_rst  = timing_rst_q;
  assign out_en      = out_en_q;
  assign mode_err    = mode_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vid_mode_seq.sv
// Self-checking bench for vid_mode_seq (3 legal modes, 255-cycle lock, 2 blank frames).
module tb_vid_mode_seq;
  import vid_mode_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned LS = 255;
  localparam int unsigned BF = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pll_lock;
  logic              vsync;
  logic [MODE_W-1:0] mode_sel;
  logic              timing_rst;
  logic              out_en;
  logic              mode_err;
  logic [7:0]        frame_count;

  vid_mode_seq_if req_if ();

  vid_mode_seq #(
    .NUM_MODES(NM), .DEFAULT_MODE(0), .LOCK_STABLE(LS), .BLANK_FRAMES(BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .vsync       (vsync),
    .req_if      (req_if),
    .mode_sel    (mode_sel),
    .timing_rst  (timing_rst),
    .out_en      (out_en),
    .mode_err    (mode_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MODE_W-1:0] req;
    logic              exp_err;
    logic              exp_ready;
    logic [MODE_W-1:0] exp_sel;
  } vec_t;

  vec_t vecs [5];
  vec_t sb [$];
  vec_t e;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " mode_sel"}, int'(mode_sel), 0);
    chk({tag, " timing_rst"}, int'(timing_rst), 1);
    chk({tag, " out_en"}, int'(out_en), 0);
    chk({tag, " ready"}, int'(req_if.mode_req_ready), 0);
    chk({tag, " mode_err"}, int'(mode_err), 0);
    chk({tag, " frame_count"}, int'(frame_count), 0);
  endtask

  initial begin
    vecs[0] = '{req: 2'd2, exp_err: 1'b0, exp_ready: 1'b1, exp_sel: 2'd2};
    vecs[1] = '{req: 2'd3, exp_err: 1'b1, exp_ready: 1'b1, exp_sel: 2'd2};
    vecs[2] = '{req: 2'd2, exp_err: 1'b0, exp_ready: 1'b1, exp_sel: 2'd2};
    vecs[3] = '{req: 2'd3, exp_err: 1'b1, exp_ready: 1'b1, exp_sel: 2'd2};
    vecs[4] = '{req: 2'd1, exp_err: 1'b0, exp_ready: 1'b0, exp_sel: 2'd2};

    rst_n = 1'b0;
    pll_lock = 1'b0;
    vsync = 1'b0;
    req_if.mode_req = '0;
    req_if.mode_req_valid = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    // Lock qualification with a one-cycle dropout restarting the count
    pll_lock = 1'b1;
    step(90);
    chk("lock pre-dropout timing_rst", int'(timing_rst), 1);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(LS);
    chk("lock count-1 timing_rst", int'(timing_rst), 1);
    step(1);
    chk("lock done timing_rst", int'(timing_rst), 0);
    chk("lock done out_en", int'(out_en), 0);

    // Blanking: two vsync edges before output is enabled
    step(3);
    vsync = 1'b1; step(1);
    chk("blank1 out_en", int'(out_en), 0);
    chk("blank1 frame_count", int'(frame_count), 1);
    vsync = 1'b0; step(4);
    vsync = 1'b1; step(1);
    chk("blank2 out_en", int'(out_en), 1);
    chk("blank2 frame_count", int'(frame_count), 2);
    chk("blank2 ready", int'(req_if.mode_req_ready), 1);
    vsync = 1'b0; step(3);

    // Mode change mid-frame, applied at the next vsync edge
    req_if.mode_req = 2'd2;
    req_if.mode_req_valid = 1'b1;
    step(1);
    req_if.mode_req_valid = 1'b0;
    chk("drain ready", int'(req_if.mode_req_ready), 0);
    chk("drain out_en", int'(out_en), 1);
    chk("drain mode_sel", int'(mode_sel), 0);
    step(5);
    chk("drain hold out_en", int'(out_en), 1);
    vsync = 1'b1; step(1);
    chk("switch timing_rst", int'(timing_rst), 1);
    chk("switch out_en", int'(out_en), 0);
    chk("switch mode_sel", int'(mode_sel), 2);
    chk("switch frame_count", int'(frame_count), 0);
    vsync = 1'b0; step(1);
    chk("post-switch timing_rst", int'(timing_rst), 0);
    step(3);
    vsync = 1'b1; step(1);
    chk("reblank1 out_en", int'(out_en), 0);
    vsync = 1'b0; step(3);
    vsync = 1'b1; step(1);
    chk("reblank2 out_en", int'(out_en), 1);
    chk("reblank2 frame_count", int'(frame_count), 2);
    vsync = 1'b0; step(2);

    // Degenerate and legal requests from the table, scoreboarded
    for (int i = 0; i < 5; i++) begin
      req_if.mode_req = vecs[i].req;
      req_if.mode_req_valid = 1'b1;
      sb.push_back(vecs[i]);
      step(1);
      req_if.mode_req_valid = 1'b0;
      e = sb.pop_front();
      chk($sformatf("vec%0d mode_err", i), int'(mode_err), int'(e.exp_err));
      chk($sformatf("vec%0d ready", i), int'(req_if.mode_req_ready), int'(e.exp_ready));
      chk($sformatf("vec%0d mode_sel", i), int'(mode_sel), int'(e.exp_sel));
      step(1);
      chk($sformatf("vec%0d mode_err pulse end", i), int'(mode_err), 0);
    end

    // Lock loss while draining with pending=1
    pll_lock = 1'b0;
    step(1);
    chk("lockloss timing_rst", int'(timing_rst), 1);
    chk("lockloss out_en", int'(out_en), 0);
    chk("lockloss ready", int'(req_if.mode_req_ready), 0);
    chk("lockloss mode_sel", int'(mode_sel), 2);
    chk("lockloss frame_count", int'(frame_count), 0);
    pll_lock = 1'b1;
    step(LS);
    chk("relock count-1 timing_rst", int'(timing_rst), 1);
    step(1);
    chk("relock timing_rst", int'(timing_rst), 0);
    vsync = 1'b1; step(1);
    vsync = 1'b0; step(2);
    vsync = 1'b1; step(1);
    chk("relock run out_en", int'(out_en), 1);
    chk("relock mode_sel", int'(mode_sel), 2);
    vsync = 1'b0; step(1);

    // Frame counter wrap in RUN
    for (int f = 0; f < 253; f++) begin
      vsync = 1'b1; step(1);
      vsync = 1'b0; step(1);
    end
    chk("wrap 255 frame_count", int'(frame_count), 255);
    vsync = 1'b1; step(1);
    chk("wrap 0 frame_count", int'(frame_count), 0);
    chk("wrap out_en", int'(out_en), 1);
    vsync = 1'b0; step(2);

    // Asynchronous reset mid-frame
    vsync = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    #10;
    rst_n = 1'b1;
    step(2);
    chk("post-reset timing_rst", int'(timing_rst), 1);
    chk("post-reset out_en", int'(out_en), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
